// File: rtl/dmem_arbiter.sv
// Two-requester data memory arbiter: round-robin between execute unit and debug port, bounded debug lock.
// Zero-latency grant; read data routed back to the issuer one cycle later; ungranted cpu requests see cpu_stall.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cpu_en,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvld,
  input  logic              dbg_en,
  input  logic              dbg_rd,
  input  logic              dbg_wr,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvld,
  output logic              mem_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dbg_q, last_dbg_d;
  logic             blk_q, blk_d;
  logic             pend_cpu_q, pend_dbg_q;
  logic             cpu_v, dbg_v, cpu_g, dbg_g;

  assign cpu_v = cpu_en & (cpu_rd ^ cpu_wr);
  assign dbg_v = dbg_en & (dbg_rd ^ dbg_wr);

  always_comb begin
    cpu_g      = 1'b0;
    dbg_g      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dbg_d = last_dbg_q;
    // blk stops a lock that hit its limit from re-locking until dbg_lock drops
    blk_d      = blk_q & dbg_lock;
    if (reset_) begin
      if (state_q == LOCKED) begin
        dbg_g = dbg_v;
      end else if (cpu_v && dbg_v) begin
        cpu_g = last_dbg_q;
        dbg_g = ~last_dbg_q;
      end else begin
        cpu_g = cpu_v;
        dbg_g = dbg_v;
      end

      if (cpu_g || dbg_g)
        last_dbg_d = dbg_g;

      if (state_q == LOCKED) begin
        if (!dbg_lock) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (int'(cnt_q) + 1 >= LOCK_MAX) begin
          state_d    = IDLE;
          cnt_d      = '0;
          last_dbg_d = 1'b1;
          blk_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dbg_g && dbg_lock && !blk_q) begin
        if (LOCK_MAX <= 1) begin
          last_dbg_d = 1'b1;
          blk_d      = 1'b1;
        end else begin
          state_d = LOCKED;
          cnt_d   = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_dbg_q <= 1'b1;
      blk_q      <= 1'b0;
      pend_cpu_q <= 1'b0;
      pend_dbg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dbg_q <= last_dbg_d;
      blk_q      <= blk_d;
      pend_cpu_q <= cpu_g & cpu_rd;
      pend_dbg_q <= dbg_g & dbg_rd;
    end
  end

  assign cpu_gnt   = cpu_g;
  assign dbg_gnt   = dbg_g;
  assign cpu_stall = reset_ & cpu_v & ~cpu_g;

  assign mem_en    = cpu_g | dbg_g;
  assign mem_rd    = (cpu_g & cpu_rd) | (dbg_g & dbg_rd);
  assign mem_wr    = (cpu_g & cpu_wr) | (dbg_g & dbg_wr);
  assign mem_addr  = cpu_g ? cpu_addr  : (dbg_g ? dbg_addr  : '0);
  assign mem_wdata = cpu_g ? cpu_wdata : (dbg_g ? dbg_wdata : '0);

  assign cpu_rvld  = pend_cpu_q;
  assign dbg_rvld  = pend_dbg_q;
  assign cpu_rdata = pend_cpu_q ? mem_rdata : '0;
  assign dbg_rdata = pend_dbg_q ? mem_rdata : '0;

endmodule
